// File: rtl/riscv_dmem_bridge.sv
// LSU-to-bus data memory bridge: buffers LSU requests, issues loads/stores on a
// single-beat valid/ready bus and returns in-order completions, including locally completed CMOs.
module riscv_dmem_bridge #(
  parameter int REQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_cacheable_i,
  input  logic [10:0] mem_req_tag_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_flush_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic [31:0] mem_data_rd_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  output logic        bus_cacheable_o,
  input  logic        bus_resp_valid_i,
  input  logic [31:0] bus_resp_data_i,
  input  logic        bus_resp_error_i
);

  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(REQ_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        cacheable;
    logic [10:0] tag;
    logic        is_cmo;
  } req_t;

  typedef struct packed {
    logic [10:0] tag;
    logic        is_load;
  } out_t;

  req_t          rq_mem [REQ_DEPTH];
  logic [PW-1:0] rq_wr_ptr, rq_rd_ptr;
  logic [CW-1:0] rq_count;
  out_t          oq_mem [REQ_DEPTH];
  logic [PW-1:0] oq_wr_ptr, oq_rd_ptr;
  logic [CW-1:0] oq_count;
  logic [CW-1:0] inflight_q, inflight_d;

  req_t new_req, head;
  out_t oq_head;
  logic req_present, capture, rq_empty, oq_empty;
  logic issue_fire, resp_pop, cmo_done, rq_pop;

  assign req_present = mem_rd_i | (|mem_wr_i) | mem_invalidate_i | mem_flush_i;
  assign capture     = req_present & mem_accept_o;

  // CMO beats store beats, store beats load; a CMO never carries strobes.
  assign new_req.addr      = mem_addr_i;
  assign new_req.wdata     = mem_data_wr_i;
  assign new_req.is_cmo    = mem_invalidate_i | mem_flush_i;
  assign new_req.wstrb     = new_req.is_cmo ? 4'b0 : mem_wr_i;
  assign new_req.cacheable = mem_cacheable_i;
  assign new_req.tag       = mem_req_tag_i;

  assign head     = rq_mem[rq_rd_ptr];
  assign oq_head  = oq_mem[oq_rd_ptr];
  assign rq_empty = (rq_count == '0);
  assign oq_empty = (oq_count == '0);

  // Bus side is driven purely from stored state, so payload holds until the handshake.
  assign bus_valid_o     = !rq_empty && !head.is_cmo;
  assign bus_addr_o      = bus_valid_o ? head.addr  : '0;
  assign bus_wdata_o     = bus_valid_o ? head.wdata : '0;
  assign bus_wstrb_o     = bus_valid_o ? head.wstrb : '0;
  assign bus_cacheable_o = bus_valid_o & head.cacheable;

  assign issue_fire = bus_valid_o & bus_ready_i;
  assign resp_pop   = bus_resp_valid_i & !oq_empty;
  // A CMO waits for every earlier bus access to complete; a response takes the ack slot first.
  assign cmo_done   = !rq_empty & head.is_cmo & oq_empty & !bus_resp_valid_i;
  assign rq_pop     = issue_fire | cmo_done;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inflight_d = inflight_q;
    case ({capture, mem_ack_o})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: storage arrays carry no reset; occupancy counters alone define validity.
  always_ff @(posedge clk_i) begin
    if (capture)    rq_mem[rq_wr_ptr] <= new_req;
    if (issue_fire) oq_mem[oq_wr_ptr] <= {head.tag, (head.wstrb == 4'b0)};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rq_wr_ptr      <= '0;
      rq_rd_ptr      <= '0;
      rq_count       <= '0;
      oq_wr_ptr      <= '0;
      oq_rd_ptr      <= '0;
      oq_count       <= '0;
      inflight_q     <= '0;
      mem_accept_o   <= 1'b1;
      mem_ack_o      <= 1'b0;
      mem_error_o    <= 1'b0;
      mem_resp_tag_o <= '0;
      mem_data_rd_o  <= '0;
    end else begin
      if (capture) rq_wr_ptr <= rq_wr_ptr + PW'(1);
      if (rq_pop)  rq_rd_ptr <= rq_rd_ptr + PW'(1);
      case ({capture, rq_pop})
        2'b10:   rq_count <= rq_count + CW'(1);
        2'b01:   rq_count <= rq_count - CW'(1);
        default: rq_count <= rq_count;
      endcase

      if (issue_fire) oq_wr_ptr <= oq_wr_ptr + PW'(1);
      if (resp_pop)   oq_rd_ptr <= oq_rd_ptr + PW'(1);
      case ({issue_fire, resp_pop})
        2'b10:   oq_count <= oq_count + CW'(1);
        2'b01:   oq_count <= oq_count - CW'(1);
        default: oq_count <= oq_count;
      endcase

      inflight_q   <= inflight_d;
      mem_accept_o <= (inflight_d != FULL);

      if (resp_pop) begin
        mem_ack_o      <= 1'b1;
        mem_error_o    <= bus_resp_error_i;
        mem_resp_tag_o <= oq_head.tag;
        mem_data_rd_o  <= oq_head.is_load ? bus_resp_data_i : '0;
      end else if (cmo_done) begin
        mem_ack_o      <= 1'b1;
        mem_error_o    <= 1'b0;
        mem_resp_tag_o <= head.tag;
        mem_data_rd_o  <= '0;
      end else begin
        mem_ack_o      <= 1'b0;
        mem_error_o    <= 1'b0;
        mem_resp_tag_o <= '0;
        mem_data_rd_o  <= '0;
      end
    end
  end

endmodule
